// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU.
//
// Ports
//   clk       in   1      clock, rising edge
//   rst       in   1      synchronous reset, active-high
//   start     in   1      request, accepted only while busy=0
//   flush     in   1      abort the operation in flight (pipeline kill)
//   op        in   2      00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend  in   WIDTH  numerator, sampled on accepted start
//   divisor   in   WIDTH  denominator, sampled on accepted start
//   busy      out  1      operation in progress
//   done      out  1      one-cycle pulse, result valid this cycle
//   result    out  WIDTH  quotient or remainder, held until the next completion
//   div_zero  out  1      divisor was zero, valid with done, held with result
//
// Handshake: a request is taken on a rising edge where start=1, flush=0 and
// busy=0. busy stays high from the cycle after acceptance until the cycle
// done pulses, so a new start may be presented in the done cycle itself.
//
// Configuration macro DIV_EARLY_OUT_EN: when defined, divide-by-zero and the
// signed overflow case jump from PREP straight to FIX, skipping the WIDTH
// iteration cycles. Results are identical either way.

module seq_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             flush,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             div_zero
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH:0]   ONE1 = {{WIDTH{1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_PREP, S_CALC, S_FIX} state_e;

   state_e           state_q, state_d;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] a_q, b_q;        // operands as accepted
   logic [WIDTH-1:0] quo_q;           // dividend magnitude shifting out, quotient shifting in
   logic [WIDTH-1:0] bmag_q;          // divisor magnitude
   logic [WIDTH-1:0] rem_q;           // partial remainder
   logic [CW-1:0]    count_q;
   logic             done_q, dz_q;
   logic [WIDTH-1:0] result_q;

   logic             accept;
   logic             is_signed, is_rem, a_neg, b_neg, b_zero, ovf;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   rem_sh, diff;
   logic [WIDTH-1:0] q_fix, r_fix, res_fix;

   assign accept    = (state_q == S_IDLE) && start && !flush;
   assign is_signed = ~op_q[0];
   assign is_rem    = op_q[1];
   assign a_neg     = is_signed & a_q[WIDTH-1];
   assign b_neg     = is_signed & b_q[WIDTH-1];
   assign b_zero    = (b_q == '0);
   assign ovf       = is_signed && (a_q == MINV) && (b_q == '1);
   // Magnitude of the most negative value wraps to itself, which is the
   // correct unsigned magnitude 2^(WIDTH-1).
   assign a_mag     = a_neg ? (~a_q + ONE) : a_q;
   assign b_mag     = b_neg ? (~b_q + ONE) : b_q;

   // One restoring step: subtract by adding the inverted divisor plus one.
   // Bit WIDTH of diff is the borrow: set means the subtraction went negative.
   assign rem_sh = {rem_q, quo_q[WIDTH-1]};
   assign diff   = rem_sh + {1'b1, ~bmag_q} + ONE1;

   always_comb begin
      q_fix = (a_neg ^ b_neg) ? (~quo_q + ONE) : quo_q;
      r_fix = a_neg ? (~rem_q + ONE) : rem_q;
      if (b_zero) begin
         q_fix = '1;
         r_fix = a_q;
      end else if (ovf) begin
         q_fix = MINV;
         r_fix = '0;
      end
      res_fix = is_rem ? r_fix : q_fix;
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; flush aborts any non-idle state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (accept) state_d = S_PREP;
         S_PREP: begin
`ifdef DIV_EARLY_OUT_EN
            if (b_zero || ovf) state_d = S_FIX;
            else               state_d = S_CALC;
`else
            state_d = S_CALC;
`endif
         end
         S_CALC: if (count_q == '0) state_d = S_FIX;
         S_FIX:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (flush && state_q != S_IDLE) state_d = S_IDLE;
   end

   // Output logic
   always_comb begin
      busy = (state_q != S_IDLE);
   end

   assign done     = done_q;
   assign result   = result_q;
   assign div_zero = dz_q;

   // Datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         quo_q    <= '0;
         bmag_q   <= '0;
         rem_q    <= '0;
         count_q  <= '0;
         done_q   <= 1'b0;
         dz_q     <= 1'b0;
         result_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  op_q <= op;
                  a_q  <= dividend;
                  b_q  <= divisor;
               end
            end
            S_PREP: begin
               quo_q   <= a_mag;
               bmag_q  <= b_mag;
               rem_q   <= '0;
               count_q <= CW'(WIDTH - 1);
            end
            S_CALC: begin
               rem_q   <= diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
               quo_q   <= {quo_q[WIDTH-2:0], ~diff[WIDTH]};
               count_q <= count_q - 1'b1;
            end
            S_FIX: begin
               if (!flush) begin
                  result_q <= res_fix;
                  dz_q     <= b_zero;
                  done_q   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Testbench for seq_divider: directed RV32M cases, latency, back-to-back,
// busy-ignore, flush, mid-operation reset and random operations checked
// against a reference model through a scoreboard queue.

module tb_seq_divider;
   localparam int W = 32;
   localparam int LAT = W + 2;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         flush = 1'b0;
   logic [1:0]   op = 2'b00;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         busy, done, div_zero;
   logic [W-1:0] result;

   int n_cmp = 0;
   int n_fail = 0;
   logic [W-1:0] exp_q[$];
   logic         exp_dz_q[$];
   logic [W-1:0] last_res = '0;

   seq_divider #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .flush(flush), .op(op),
      .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
      .result(result), .div_zero(div_zero)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Scoreboard: every done pulse pops one expected result
   always @(negedge clk) begin
      if (!rst && done) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected_done: result=%h with no expected entry", result);
         end else begin
            logic [W-1:0] er;
            logic         ed;
            er = exp_q.pop_front();
            ed = exp_dz_q.pop_front();
            if (result !== er || div_zero !== ed) begin
               n_fail++;
               $display("FAIL sb_result: got %h dz=%b, expected %h dz=%b", result, div_zero, er, ed);
            end
         end
      end
   end

   function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                          input logic [W-1:0] b, output logic dz);
      logic [W-1:0] q, r;
      dz = (b == '0);
      if (b == '0) begin
         q = '1; r = a;
      end else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000; r = '0;
      end else if (!o[0]) begin
         q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
      end else begin
         q = a / b; r = a % b;
      end
      return o[1] ? r : q;
   endfunction

   // Drive a one-cycle start once the divider is idle; returns #1 after the accept edge
   task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      int guard = 0;
      while (busy && guard < 100) begin
         @(posedge clk); #1; guard++;
      end
      if (busy) begin
         n_cmp++; n_fail++;
         $display("FAIL issue_timeout: busy=%b, required 0", busy);
      end
      op = o; dividend = a; divisor = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      dividend = $urandom; divisor = $urandom; op = 2'($urandom_range(0, 3));
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      do begin
         @(posedge clk); #1; lat++;
      end while (!done && lat < 80);
   endtask

   task automatic push_exp(input logic [W-1:0] r, input logic dz);
      exp_q.push_back(r);
      exp_dz_q.push_back(dz);
      last_res = r;
   endtask

   task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] er, input logic ed, input string name);
      int lat;
      issue(o, a, b);
      push_exp(er, ed);
      wait_done(lat);
`ifdef DIV_EARLY_OUT_EN
      if (!(b == '0 || (!o[0] && a == 32'h8000_0000 && b == '1))) begin
`else
      begin
`endif
         n_cmp++;
         if (lat !== LAT) begin
            n_fail++;
            $display("FAIL latency_%s: done after %0d cycles, required %0d", name, lat, LAT);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || div_zero !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: busy=%b done=%b result=%h dz=%b, required 0 0 0 0",
                  busy, done, result, div_zero);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      run_op(2'b01, 32'd100, 32'd7, 32'd14, 1'b0, "divu_100_7");
      run_op(2'b11, 32'd100, 32'd7, 32'd2, 1'b0, "remu_100_7");
      run_op(2'b00, -32'sd7, 32'd2, 32'hFFFF_FFFD, 1'b0, "div_m7_2");
      run_op(2'b10, -32'sd7, 32'd2, 32'hFFFF_FFFF, 1'b0, "rem_m7_2");
      run_op(2'b10, 32'd7, -32'sd2, 32'd1, 1'b0, "rem_7_m2");
      run_op(2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, "divu_5_0");
      run_op(2'b11, 32'd5, 32'd0, 32'd5, 1'b1, "remu_5_0");
      run_op(2'b00, -32'sd7, 32'd0, 32'hFFFF_FFFF, 1'b1, "div_m7_0");
      run_op(2'b10, -32'sd7, 32'd0, 32'hFFFF_FFF9, 1'b1, "rem_m7_0");
      run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, "div_ovf");
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, "rem_ovf");
      run_op(2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, "divu_max_1");
      run_op(2'b00, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0, "div_min_1");
   endtask

   task automatic test_busy_ignore();
      int lat;
      issue(2'b01, 32'd100, 32'd7);
      push_exp(32'd14, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      op = 2'b00; dividend = 32'd9; divisor = 32'd3; start = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(lat);
      n_cmp++;
      if (lat + 8 !== LAT) begin
         n_fail++;
         $display("FAIL busy_ignore_latency: done after %0d cycles, required %0d", lat + 8, LAT);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_ignore_idle: busy=%b, required 0", busy);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      issue(2'b11, 32'd100, 32'd7);
      push_exp(32'd2, 1'b0);
      wait_done(lat);
      // Present the next request in the done cycle
      op = 2'b00; dividend = -32'sd7; divisor = 32'd2; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      push_exp(32'hFFFF_FFFD, 1'b0);
      n_cmp++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_accept: busy=%b, required 1", busy);
      end
      wait_done(lat);
      n_cmp++;
      if (lat !== LAT) begin
         n_fail++;
         $display("FAIL b2b_latency: done after %0d cycles, required %0d", lat, LAT);
      end
   endtask

   task automatic test_flush();
      int seen = 0;
      issue(2'b01, 32'd1000, 32'd3);
      repeat (11) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      n_cmp++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_busy: busy=%b, required 0", busy);
      end
      for (int i = 0; i < 40; i++) begin
         if (done) seen++;
         @(posedge clk); #1;
      end
      n_cmp++;
      if (seen !== 0) begin
         n_fail++;
         $display("FAIL flush_no_done: %0d done pulses, required 0", seen);
      end
      n_cmp++;
      if (result !== last_res) begin
         n_fail++;
         $display("FAIL flush_result_held: result=%h, required %h", result, last_res);
      end
      // flush and start together in idle: nothing accepted
      op = 2'b01; dividend = 32'd50; divisor = 32'd5; start = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      n_cmp++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_start_idle: busy=%b, required 0", busy);
      end
   endtask

   task automatic test_reset_mid_calc();
      issue(2'b00, 32'd12345, 32'd17);
      repeat (15) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || div_zero !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_calc: busy=%b done=%b result=%h dz=%b, required 0 0 0 0",
                  busy, done, result, div_zero);
      end
      last_res = '0;
   endtask

   task automatic test_random(input int n);
      for (int i = 0; i < n; i++) begin
         logic [1:0]   o;
         logic [W-1:0] a, b, er;
         logic         ed;
         o = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 5))
            0: a = 32'h8000_0000;
            1: a = W'($urandom_range(0, 20));
            2: a = -W'($urandom_range(0, 20));
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 6))
            0: b = '0;
            1: b = '1;
            2: b = W'($urandom_range(1, 9));
            3: b = -W'($urandom_range(1, 9));
            default: b = $urandom >> $urandom_range(0, 31);
         endcase
         er = model(o, a, b, ed);
         run_op(o, a, b, er, ed, "random");
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_busy_ignore();
      test_back_to_back();
      test_flush();
      test_reset_mid_calc();
      test_random(1000);
      repeat (5) @(posedge clk);
      #1;
      n_cmp++;
      if (exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL sb_leftover: %0d expected results never produced, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
